// File: rtl/nios2_clocks_pkg.sv
// Shared types and helpers for the divided-clock generator: FSM states, the
// divide/phase clamp, and the counter start value used when channels realign.
package nios2_clocks_pkg;

  localparam int unsigned MIN_DIV = 2;
  localparam int unsigned WORD_W  = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    StAlign,
    StLockWait,
    StRun
  } state_e;

  typedef struct packed {
    word_t div;
    word_t phase;
  } div_cfg_t;

  // A phase that does not fit inside the period is dropped rather than wrapped.
  function automatic div_cfg_t clamp_cfg(input word_t div, input word_t phase);
    div_cfg_t c;
    c.div   = (div < word_t'(MIN_DIV)) ? word_t'(MIN_DIV) : div;
    c.phase = (phase < c.div) ? phase : '0;
    return c;
  endfunction

  function automatic word_t align_start(input word_t div, input word_t phase);
    return (phase == '0) ? '0 : div - phase;
  endfunction

endpackage

// File: rtl/nios2_clocks_div_gen_if.sv
// Configuration handshake between a host and the divided-clock generator.
interface nios2_clocks_div_gen_if #(
  parameter int unsigned CH_W  = 1,
  parameter int unsigned CNT_W = 16
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_chan;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_phase;

  modport master (
    output cfg_valid,
    output cfg_chan,
    output cfg_div,
    output cfg_phase,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_chan,
    input  cfg_div,
    input  cfg_phase,
    output cfg_ready
  );

endinterface

// File: rtl/nios2_clocks_div_chan.sv
// One divided-clock channel: divide/phase registers, period counter and the
// registered clock / clock-enable outputs derived from the next counter value.
module nios2_clocks_div_chan
  import nios2_clocks_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned DIV_INIT = 2
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] wr_phase,
  output logic             outclk,
  output logic             clk_en
);

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_next;
  logic             outclk_q, outclk_d;
  logic             clk_en_q, clk_en_d;
  div_cfg_t         cfg_c;
  word_t            start_w;

  always_comb begin
    cfg_c    = clamp_cfg(word_t'(wr_div), word_t'(wr_phase));
    start_w  = align_start(word_t'(div_q), word_t'(phase_q));
    cnt_next = (cnt_q == div_q - CNT_W'(1)) ? '0 : cnt_q + CNT_W'(1);

    div_d    = div_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    outclk_d = outclk_q;
    clk_en_d = clk_en_q;

    if (wr) begin
      div_d   = cfg_c.div[CNT_W-1:0];
      phase_d = cfg_c.phase[CNT_W-1:0];
    end

    if (load) begin
      cnt_d    = start_w[CNT_W-1:0];
      outclk_d = 1'b0;
      clk_en_d = 1'b0;
    end else if (run) begin
      // Outputs follow the value the counter is about to hold: no added latency.
      cnt_d    = cnt_next;
      outclk_d = (cnt_next < (div_q >> 1));
      clk_en_d = (cnt_next == '0);
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= CNT_W'(DIV_INIT);
      phase_q  <= '0;
      cnt_q    <= '0;
      outclk_q <= 1'b0;
      clk_en_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      outclk_q <= outclk_d;
      clk_en_q <= clk_en_d;
    end
  end

  assign outclk = outclk_q;
  assign clk_en = clk_en_q;

  // Helpers work on a full word; the bits above CNT_W are always zero here.
  if (CNT_W < WORD_W) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^{cfg_c.div[WORD_W-1:CNT_W], cfg_c.phase[WORD_W-1:CNT_W],
                         start_w[WORD_W-1:CNT_W]};
  end

endmodule

// File: rtl/nios2_clocks_div_gen.sv
// Multi-output divided-clock generator: per-channel divide/phase, clock enables,
// and a lock indication re-run after every accepted reconfiguration.
module nios2_clocks_div_gen
  import nios2_clocks_pkg::*;
#(
  parameter int unsigned NUM_CLOCKS = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DIV_INIT   = 2,
  parameter int unsigned LOCK_DELAY = 16,
  parameter int unsigned CH_W       = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  nios2_clocks_div_gen_if.slave cfg,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] clk_en,
  output logic                  locked
);

  localparam int unsigned LC_W = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;

  state_e                state_q, state_d;
  logic [LC_W-1:0]       lock_cnt_q, lock_cnt_d;
  logic                  locked_q, locked_d;
  logic                  load, run, ready, xfer, chan_ok;
  logic [NUM_CLOCKS-1:0] wr_en;

  assign chan_ok = (32'(cfg.cfg_chan) < NUM_CLOCKS);

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    load       = 1'b0;
    run        = 1'b0;
    ready      = 1'b0;

    case (state_q)
      StAlign: begin
        load       = 1'b1;
        lock_cnt_d = '0;
        locked_d   = 1'b0;
        state_d    = StLockWait;
      end
      StLockWait: begin
        run        = 1'b1;
        lock_cnt_d = lock_cnt_q + LC_W'(1);
        if (lock_cnt_q == LC_W'(LOCK_DELAY - 1)) begin
          state_d  = StRun;
          locked_d = 1'b1;
        end
      end
      StRun: begin
        run   = 1'b1;
        ready = 1'b1;
        // Out-of-range channels are consumed silently and keep the lock.
        if (cfg.cfg_valid && chan_ok) begin
          state_d  = StAlign;
          locked_d = 1'b0;
        end
      end
      default: state_d = StAlign;
    endcase

    xfer = cfg.cfg_valid && ready;
    for (int i = 0; i < int'(NUM_CLOCKS); i++) begin
      wr_en[i] = xfer && (32'(cfg.cfg_chan) == i);
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StAlign;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign cfg.cfg_ready = ready;
  assign locked        = locked_q;

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
    nios2_clocks_div_chan #(
      .CNT_W    (CNT_W),
      .DIV_INIT (DIV_INIT)
    ) u_chan (
      .refclk   (refclk),
      .rst_n    (rst_n),
      .load     (load),
      .run      (run),
      .wr       (wr_en[i]),
      .wr_div   (cfg.cfg_div),
      .wr_phase (cfg.cfg_phase),
      .outclk   (outclk[i]),
      .clk_en   (clk_en[i])
    );
  end

endmodule

// File: tb/tb_nios2_clocks_div_gen.sv
// Randomised bench for nios2_clocks_div_gen with a cycle-level reference model
// feeding a scoreboard that is drained against the DUT on every falling edge.
module tb_nios2_clocks_div_gen;

  localparam int unsigned NUM        = 2;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned DIV_INIT   = 2;
  localparam int unsigned LOCK_DELAY = 16;
  localparam int unsigned CH_W       = 2;

  logic           refclk = 1'b0;
  logic           rst_n  = 1'b0;
  logic [NUM-1:0] outclk;
  logic [NUM-1:0] clk_en;
  logic           locked;

  nios2_clocks_div_gen_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg ();

  nios2_clocks_div_gen #(
    .NUM_CLOCKS (NUM),
    .CNT_W      (CNT_W),
    .DIV_INIT   (DIV_INIT),
    .LOCK_DELAY (LOCK_DELAY),
    .CH_W       (CH_W)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .cfg    (cfg),
    .outclk (outclk),
    .clk_en (clk_en),
    .locked (locked)
  );

  always #5 refclk = ~refclk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [NUM-1:0] outclk;
    logic [NUM-1:0] clk_en;
    logic           locked;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: after a realignment each channel's position in its period
  // is simply (start + cycles_since_align) mod div.
  longint m_div[NUM];
  longint m_phase[NUM];
  longint m_k;
  bit     m_align;
  bit     m_locked;

  function automatic void model_reset();
    for (int c = 0; c < int'(NUM); c++) begin
      m_div[c]   = DIV_INIT;
      m_phase[c] = 0;
    end
    m_k      = 0;
    m_align  = 1'b1;
    m_locked = 1'b0;
  endfunction

  initial begin
    exp_t   e;
    bit     take;
    longint start, pos, d, p;
    model_reset();
    forever begin
      @(posedge refclk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
        exp_q.delete();
      end else begin
        take = cfg.cfg_valid && m_locked;
        e    = '0;
        if (m_align) begin
          m_align  = 1'b0;
          m_k      = 0;
          m_locked = 1'b0;
        end else begin
          m_k++;
          for (int c = 0; c < int'(NUM); c++) begin
            start          = (m_phase[c] == 0) ? 0 : m_div[c] - m_phase[c];
            pos            = (start + m_k) % m_div[c];
            e.outclk[c]    = (pos < m_div[c] / 2);
            e.clk_en[c]    = (pos == 0);
          end
          m_locked = (m_k >= LOCK_DELAY);
          if (take && (int'(cfg.cfg_chan) < int'(NUM))) begin
            d = (cfg.cfg_div < 2) ? 2 : longint'(cfg.cfg_div);
            p = (longint'(cfg.cfg_phase) < d) ? longint'(cfg.cfg_phase) : 0;
            m_div[cfg.cfg_chan]   = d;
            m_phase[cfg.cfg_chan] = p;
            m_align  = 1'b1;
            m_locked = 1'b0;
          end
        end
        e.locked = m_locked;
        exp_q.push_back(e);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge refclk);
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outclk", 32'(outclk), 32'(e.outclk));
        check("clk_en", 32'(clk_en), 32'(e.clk_en));
        check("locked", 32'(locked), 32'(e.locked));
        check("cfg_ready", 32'(cfg.cfg_ready), 32'(e.locked));
      end
    end
  end

  task automatic wait_lock(input string name);
    int n = 0;
    while (!locked && n < 40) begin
      @(posedge refclk);
      #1;
      n++;
    end
    check(name, 32'(n), 32'(1 + LOCK_DELAY));
  endtask

  task automatic do_write(input int chan, input int div, input int phase, output int cycles);
    bit r;
    cycles          = 0;
    cfg.cfg_valid   = 1'b1;
    cfg.cfg_chan    = CH_W'(chan);
    cfg.cfg_div     = CNT_W'(div);
    cfg.cfg_phase   = CNT_W'(phase);
    forever begin
      r = cfg.cfg_ready;
      @(posedge refclk);
      #1;
      cycles++;
      if (r) break;
      if (cycles > 200) begin
        tests++;
        fails++;
        $display("FAIL handshake_timeout: got no ready after %0d cycles, required <= 200", cycles);
        break;
      end
    end
    cfg.cfg_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, sel, dv, ph;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_chan  = '0;
    cfg.cfg_div   = '0;
    cfg.cfg_phase = '0;

    // Reset values while held in reset.
    #12;
    check("rst_outclk", 32'(outclk), 32'd0);
    check("rst_clk_en", 32'(clk_en), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_ready", 32'(cfg.cfg_ready), 32'd0);
    #11 rst_n = 1'b1;
    wait_lock("lock_latency_boot");

    // Directed: divide/phase, odd divide, clamps.
    idle(5);
    do_write(0, 4, 0, cyc);
    idle(30);
    do_write(1, 4, 1, cyc);
    idle(30);
    do_write(0, 5, 0, cyc);
    idle(30);
    do_write(1, 1, 7, cyc);
    idle(30);
    do_write(0, 6, 6, cyc);
    idle(30);

    // Out-of-range channel is taken immediately in RUN and changes nothing.
    do_write(3, 9, 3, cyc);
    check("invalid_chan_accept", 32'(cyc), 32'd1);
    check("invalid_chan_locked", 32'(locked), 32'd1);
    idle(10);

    // Reset in the middle of the lock sequence drops the written config.
    do_write(0, 8, 2, cyc);
    repeat (6) @(posedge refclk);
    #2 rst_n = 1'b0;
    #1;
    check("async_outclk", 32'(outclk), 32'd0);
    check("async_clk_en", 32'(clk_en), 32'd0);
    check("async_locked", 32'(locked), 32'd0);
    repeat (2) @(posedge refclk);
    #3 rst_n = 1'b1;
    wait_lock("lock_latency_rerst");
    idle(12);

    // Randomised reconfiguration, including requests held across non-RUN states.
    for (int t = 0; t < 24; t++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       dv = 0;
        1:       dv = 1;
        2:       dv = 'hFFFF;
        default: dv = int'($urandom_range(2, 12));
      endcase
      ph = int'($urandom_range(0, 14));
      do_write(int'($urandom_range(0, 3)), dv, ph, cyc);
      idle(int'($urandom_range(0, 30)));
    end

    idle(40);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nios2_clocks_div_gen.md
Name: nios2_clocks_div_gen

Overview:
- Parametrised, fully synchronous multi-output clock generator that sits downstream of the system PLL output.
- Derives NUM_CLOCKS divided clocks from one reference clock. Each output has a runtime-programmable divide ratio and phase offset, given in reference cycles.
- Also produces a per-channel one-cycle clock-enable pulse and a locked indication.
- Reconfiguration uses a valid/ready handshake. Every accepted change realigns all channels and re-runs the lock sequence.

Parameters:
- NUM_CLOCKS, 2, number of output channels (1..16).
- CNT_W, 16, width of divide and phase fields and of the per-channel counters.
- DIV_INIT, 2, divide ratio loaded into every channel at reset (must be ≥2).
- LOCK_DELAY, 16, reference cycles from realignment to assertion of locked (≥1).
- CH_W, $clog2(NUM_CLOCKS) with a minimum of 1, width of the channel select.

Ports:
- refclk  in  1  reference clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  block accepts configuration this cycle.
- cfg_chan  in  CH_W  target channel.
- cfg_div  in  CNT_W  requested divide ratio.
- cfg_phase  in  CNT_W  requested rising-edge lag, in refclk cycles.
- outclk  out  NUM_CLOCKS  divided clock outputs, registered.
- clk_en  out  NUM_CLOCKS  one-refclk pulse per output period, registered.
- locked  out  1  all channels aligned and stable.

Behaviour:
- Reset (async assert, sync release):
  - outclk=0, clk_en=0, locked=0.
  - Each channel: div=DIV_INIT, phase=0, cnt=0.
  - FSM enters ALIGN.
- FSM states: ALIGN, LOCKWAIT, RUN.
- ALIGN (exactly 1 cycle):
  - Every channel loads cnt ← (phase==0 ? 0 : div−phase).
  - outclk and clk_en are driven 0.
  - Next state is LOCKWAIT with lock counter = 0.
- LOCKWAIT:
  - Counters run.
  - The lock counter increments each cycle.
  - At the edge where lock counter == LOCK_DELAY−1, go to RUN and set locked=1.
- RUN:
  - Counters run; locked=1.
- Counting, in LOCKWAIT and RUN:
  - cnt_next = (cnt == div−1) ? 0 : cnt+1.
  - outclk[i] ← (cnt_next < div>>1).
  - clk_en[i] ← (cnt_next == 0).
  - Outputs are therefore aligned with the counter value and carry no extra latency.
  - Odd div gives a high time of floor(div/2) cycles and a low time of ceil(div/2) cycles.
- Handshake:
  - cfg_ready = 1 only in RUN.
  - Transfer occurs when cfg_valid && cfg_ready.
  - cfg_valid may be held in other states; it waits until RUN.
- On transfer with cfg_chan < NUM_CLOCKS:
  - Store div' = max(cfg_div, 2).
  - Store phase' = (cfg_phase < div') ? cfg_phase : 0.
  - locked ← 0 at the same edge; FSM → ALIGN. All channels realign, not only the target.
- On transfer with cfg_chan ≥ NUM_CLOCKS:
  - The transfer is consumed but has no effect.
  - FSM stays in RUN; locked stays 1.
- Reset mid-operation: all state returns to reset values immediately, including configuration previously written.
- cfg_div = 0, 1, or all-ones: the clamp covers 0 and 1; all-ones is legal and gives a counter period of 2^CNT_W−1.

Decomposition:
- Package nios2_clocks_pkg holds:
  - the state enum (ALIGN/LOCKWAIT/RUN);
  - MIN_DIV=2;
  - a function computing the clamped div/phase pair;
  - a function computing the ALIGN start value.
- Sub-module nios2_clocks_div_chan holds one channel's div/phase registers, counter and output flops. It has a load strobe, a run enable and a config write strobe. The top instantiates it NUM_CLOCKS times with a generate loop and owns the FSM, lock counter and handshake.

Test Plan:
1. Reset defaults (DIV_INIT=2, LOCK_DELAY=16): release rst_n → locked rises exactly 17 cycles after release (1 ALIGN + 16 LOCKWAIT); both outclk toggle every cycle; clk_en high every 2nd cycle; cfg_ready=0 before locked.
2. Divide and phase: write ch0 div=4 phase=0, then ch1 div=4 phase=1 → after each write locked drops for 17 cycles. outclk pattern is 1100 repeating; ch1 rising edge lags ch0 by exactly 1 cycle; clk_en pulses coincide with the rising edges.
3. Odd divide: ch0 div=5 → outclk high 2 cycles, low 3 cycles; clk_en one pulse per 5 cycles.
4. Clamping: cfg_div=1, phase=7 → behaves as div=2, phase=0. cfg_div=6, phase=6 → phase=0.
5. Invalid channel, NUM_CLOCKS=2: cfg_chan=3 with valid high in RUN → accepted in 1 cycle; locked stays 1; outputs undisturbed.
6. Reset mid-LOCKWAIT after writing div=8: assert rst_n low at lock count 5 → outputs go 0 asynchronously; after release, channels run at DIV_INIT=2 and the full 17-cycle lock sequence repeats.
